// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush and multdiv handshake control
// Drives hold/bubble/flush for PC, F/D, D/X and X/M plus multdiv start/complete/watchdog.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_X,
  input  logic        branch_taken,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        stall_F,
  output logic        stall_DX,
  output logic        bubble_DX,
  output logic        flush_FD,
  output logic        bubble_XM,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        md_result_valid,
  output logic        md_exc,
  output logic        md_timeout
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BEX   = 5'b10110;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;
  localparam logic [5:0] CNT_LAST = 6'(MD_TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  logic [4:0] d_op, d_rd, d_rs, d_rt;
  logic [4:0] x_op, x_rd, x_alu;
  assign d_op  = IR_D[31:27];
  assign d_rd  = IR_D[26:22];
  assign d_rs  = IR_D[21:17];
  assign d_rt  = IR_D[16:12];
  assign x_op  = IR_X[31:27];
  assign x_rd  = IR_X[26:22];
  assign x_alu = IR_X[6:2];

  logic unused_bits;
  assign unused_bits = ^{IR_D[11:7], IR_D[1:0], IR_X[21:7], IR_X[1:0]};

  logic       x_mul, x_div, x_lw;
  assign x_mul = (x_op == OP_RTYPE) && (x_alu == ALU_MUL);
  assign x_div = (x_op == OP_RTYPE) && (x_alu == ALU_DIV);
  assign x_lw  = (x_op == OP_LW);

  // The sw data register (Rd) is forwarded from M, so only its base register counts.
  logic       src1_en, src2_en;
  logic [4:0] src1, src2;
  always_comb begin
    src1_en = 1'b0;
    src2_en = 1'b0;
    src1    = 5'd0;
    src2    = 5'd0;
    case (d_op)
      OP_RTYPE: begin src1_en = 1'b1; src1 = d_rs; src2_en = 1'b1; src2 = d_rt; end
      OP_ADDI, OP_LW, OP_SW: begin src1_en = 1'b1; src1 = d_rs; end
      OP_BNE, OP_BLT: begin src1_en = 1'b1; src1 = d_rd; src2_en = 1'b1; src2 = d_rs; end
      OP_JR:    begin src1_en = 1'b1; src1 = d_rd; end
      OP_BEX:   begin src1_en = 1'b1; src1 = 5'd30; end
      default:  ;
    endcase
  end

  logic load_use;
  assign load_use = x_lw && (x_rd != 5'd0) &&
                    ((src1_en && (src1 == x_rd)) || (src2_en && (src2 == x_rd)));

  logic stall_f_c, stall_dx_c, bubble_dx_c, flush_fd_c, bubble_xm_c;
  logic mult_c, div_c, valid_c, exc_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    stall_f_c   = 1'b0;
    stall_dx_c  = 1'b0;
    bubble_dx_c = 1'b0;
    flush_fd_c  = 1'b0;
    bubble_xm_c = 1'b0;
    mult_c      = 1'b0;
    div_c       = 1'b0;
    valid_c     = 1'b0;
    exc_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (x_mul || x_div) begin
          mult_c      = x_mul;
          div_c       = x_div;
          stall_f_c   = 1'b1;
          stall_dx_c  = 1'b1;
          bubble_xm_c = 1'b1;
          state_d     = BUSY;
          cnt_d       = 6'd0;
        end
        if (branch_taken) begin
          flush_fd_c  = 1'b1;
          bubble_dx_c = 1'b1;
        end else if (load_use) begin
          stall_f_c   = 1'b1;
          bubble_dx_c = 1'b1;
        end
      end
      BUSY: begin
        if (md_ready) begin
          valid_c = 1'b1;
          exc_c   = md_exception;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog expiry: give up on the op and let the pipeline move on.
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          stall_f_c   = 1'b1;
          stall_dx_c  = 1'b1;
          bubble_xm_c = 1'b1;
          cnt_d       = cnt_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_F         = reset_n & stall_f_c;
  assign stall_DX        = reset_n & stall_dx_c;
  assign bubble_DX       = reset_n & bubble_dx_c;
  assign flush_FD        = reset_n & flush_fd_c;
  assign bubble_XM       = reset_n & bubble_xm_c;
  assign ctrl_MULT       = reset_n & mult_c;
  assign ctrl_DIV        = reset_n & div_c;
  assign md_result_valid = reset_n & valid_c;
  assign md_exc          = reset_n & exc_c;
  assign md_timeout      = reset_n & timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
// Reference model tracks the multdiv op by start cycle and elapsed time; directed checks pin it.
module tb_hazard_ctrl;
  localparam int TO = 40;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] IR_D = 32'h0;
  logic [31:0] IR_X = 32'h0;
  logic        branch_taken = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;
  logic stall_F, stall_DX, bubble_DX, flush_FD, bubble_XM;
  logic ctrl_MULT, ctrl_DIV, md_result_valid, md_exc, md_timeout;

  int n_chk = 0;
  int n_fail = 0;

  hazard_ctrl #(.MD_TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .IR_D(IR_D), .IR_X(IR_X),
    .branch_taken(branch_taken), .md_ready(md_ready), .md_exception(md_exception),
    .stall_F(stall_F), .stall_DX(stall_DX), .bubble_DX(bubble_DX), .flush_FD(flush_FD),
    .bubble_XM(bubble_XM), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .md_result_valid(md_result_valid), .md_exc(md_exc), .md_timeout(md_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rd, input int rs, input int rt, input int alu);
    return {5'b00000, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'b00};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rd, input int rs);
    return {5'(op), 5'(rd), 5'(rs), 17'd0};
  endfunction

  function automatic bit is_md(input logic [31:0] ir);
    return ir[31:27] == 5'd0 && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
  endfunction

  function automatic bit reads_reg(input logic [31:0] ir, input int r);
    int rd, rs, rt;
    rd = int'(ir[26:22]);
    rs = int'(ir[21:17]);
    rt = int'(ir[16:12]);
    case (int'(ir[31:27]))
      0:       return r == rs || r == rt;
      5, 8, 7: return r == rs;
      2, 6:    return r == rd || r == rs;
      4:       return r == rd;
      22:      return r == 30;
      default: return 1'b0;
    endcase
  endfunction

  // Model state: whether an op is outstanding, the cycle it started, sticky timeout.
  bit m_active = 0;
  int m_start = 0;
  bit m_tflag = 0;
  int cyc = 0;

  always @(negedge clock) begin
    logic [9:0] exp_v, act_v;
    int el;
    exp_v = '0;
    el = cyc - m_start;
    if (reset_n) begin
      if (m_active) begin
        if (md_ready) begin
          exp_v[2] = 1'b1;
          exp_v[1] = md_exception;
        end else if (el < TO) begin
          exp_v[9] = 1'b1; exp_v[8] = 1'b1; exp_v[5] = 1'b1;
        end
      end else begin
        if (is_md(IR_X)) begin
          exp_v[9] = 1'b1; exp_v[8] = 1'b1; exp_v[5] = 1'b1;
          exp_v[4] = (IR_X[6:2] == 5'd6);
          exp_v[3] = (IR_X[6:2] == 5'd7);
        end
        if (branch_taken) begin
          exp_v[6] = 1'b1; exp_v[7] = 1'b1;
        end else if (IR_X[31:27] == 5'd8 && IR_X[26:22] != 5'd0 && reads_reg(IR_D, int'(IR_X[26:22]))) begin
          exp_v[9] = 1'b1; exp_v[7] = 1'b1;
        end
      end
      exp_v[0] = m_tflag;
    end
    act_v = {stall_F, stall_DX, bubble_DX, flush_FD, bubble_XM,
             ctrl_MULT, ctrl_DIV, md_result_valid, md_exc, md_timeout};
    chk($sformatf("model cycle %0d", cyc), 32'(act_v), 32'(exp_v));
    if (!reset_n) begin
      m_active = 0;
      m_tflag = 0;
    end else if (m_active) begin
      if (md_ready) m_active = 0;
      else if (el == TO) begin
        m_active = 0;
        m_tflag = 1;
      end
    end else if (is_md(IR_X)) begin
      m_active = 1;
      m_start = cyc;
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic look;
    @(negedge clock);
    #1;
  endtask

  logic [31:0] MUL, DIV;

  initial begin
    MUL = rtype(3, 1, 2, 6);
    DIV = rtype(4, 1, 2, 7);
    tick; tick;
    look;
    chk("reset stall_F", 32'(stall_F), 32'd0);
    chk("reset md_timeout", 32'(md_timeout), 32'd0);
    tick; reset_n = 1'b1;

    // Load-use cases
    IR_X = itype(8, 5, 2); IR_D = rtype(7, 5, 1, 0);
    look;
    chk("lu add stall_F", 32'(stall_F), 32'd1);
    chk("lu add bubble_DX", 32'(bubble_DX), 32'd1);
    tick; IR_D = itype(7, 5, 3);
    look;
    chk("lu sw stall_F", 32'(stall_F), 32'd0);
    chk("lu sw bubble_DX", 32'(bubble_DX), 32'd0);
    tick; IR_X = itype(8, 0, 2); IR_D = rtype(7, 0, 1, 0);
    look;
    chk("lu r0 stall_F", 32'(stall_F), 32'd0);
    tick; IR_X = itype(8, 30, 2); IR_D = itype(22, 0, 0);
    look;
    chk("lu bex stall_F", 32'(stall_F), 32'd1);

    // Taken branch
    tick; IR_X = itype(6, 1, 2); IR_D = rtype(7, 1, 2, 0); branch_taken = 1'b1;
    look;
    chk("br flush_FD", 32'(flush_FD), 32'd1);
    chk("br bubble_DX", 32'(bubble_DX), 32'd1);
    chk("br stall_F", 32'(stall_F), 32'd0);
    tick; branch_taken = 1'b0; IR_X = 32'h0; IR_D = 32'h0;

    // Multiply, md_ready at N+17, then back-to-back divide with exception
    tick; IR_X = MUL;
    look;
    chk("mul start ctrl_MULT", 32'(ctrl_MULT), 32'd1);
    chk("mul start bubble_XM", 32'(bubble_XM), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      tick;
      look;
      if (i == 1) chk("mul N+1 ctrl_MULT", 32'(ctrl_MULT), 32'd0);
      if (i == 16) chk("mul N+16 stall_DX", 32'(stall_DX), 32'd1);
    end
    tick; md_ready = 1'b1;
    look;
    chk("mul N+17 valid", 32'(md_result_valid), 32'd1);
    chk("mul N+17 stall_F", 32'(stall_F), 32'd0);
    tick; md_ready = 1'b0; IR_X = DIV;
    look;
    chk("b2b ctrl_DIV", 32'(ctrl_DIV), 32'd1);
    tick; tick; tick; md_ready = 1'b1; md_exception = 1'b1;
    look;
    chk("div md_exc", 32'(md_exc), 32'd1);
    chk("div valid", 32'(md_result_valid), 32'd1);
    tick; md_ready = 1'b0; md_exception = 1'b0; IR_X = 32'h0;

    // Watchdog timeout
    tick; IR_X = DIV;
    for (int i = 1; i <= TO - 1; i++) begin
      tick;
      look;
      if (i == TO - 1) chk("to last stall_F", 32'(stall_F), 32'd1);
    end
    tick;
    look;
    chk("to release stall_F", 32'(stall_F), 32'd0);
    chk("to release valid", 32'(md_result_valid), 32'd0);
    tick; IR_X = 32'h0;
    look;
    chk("to sticky md_timeout", 32'(md_timeout), 32'd1);
    tick; tick;
    look;
    chk("to still md_timeout", 32'(md_timeout), 32'd1);

    // Reset mid-BUSY
    tick; IR_X = MUL;
    for (int i = 0; i < 5; i++) tick;
    look;
    chk("pre-reset stall_F", 32'(stall_F), 32'd1);
    tick; reset_n = 1'b0;
    look;
    chk("in reset stall_F", 32'(stall_F), 32'd0);
    chk("in reset md_timeout", 32'(md_timeout), 32'd0);
    tick; reset_n = 1'b1; IR_X = 32'h0;
    look;
    chk("post reset stall_F", 32'(stall_F), 32'd0);
    chk("post reset md_timeout", 32'(md_timeout), 32'd0);
    tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
